// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S frame feeder: serializer word width,
// channel encoding of the word-select line, feeder states and the helper
// that left-aligns a sample inside the serializer word.
package i2s_pkg;

    localparam int I2S_WORD_W = 32;

    // Word-select encoding as seen on lrclk.
    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_ch_e;

    // Feeder state: IDLE until the first left-channel boundary, ARMED after.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } feeder_state_e;

    // Place a DATA_W-bit sample (held in the low bits) so its MSB lands at
    // bit 31; the vacated LSBs are zero. No scaling or rounding.
    function automatic logic [I2S_WORD_W-1:0] align_word(
        input logic [I2S_WORD_W-1:0] sample,
        input int unsigned           data_w
    );
        return sample << (I2S_WORD_W - data_w);
    endfunction

endpackage

// File: rtl/i2s_frame_feeder_if.sv
// Stereo frame handshake between the DSP core (master) and the frame
// feeder (slave). A frame moves when s_valid && s_ready.
interface i2s_frame_feeder_if #(
    parameter int DATA_W = 24
);

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_left;
    logic [DATA_W-1:0] s_right;

    modport master (
        output s_valid,
        output s_left,
        output s_right,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_left,
        input  s_right,
        output s_ready
    );

endinterface

// File: rtl/i2s_sample_fifo.sv
// Synchronous FIFO of stereo frames. Pointers wrap modulo DEPTH (a power of
// two); the fill level is a separate counter so full and empty are
// distinguishable. Reset flushes by clearing pointers and level only.
module i2s_sample_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;

    assign full_s  = (level_r == LVL_W'(DEPTH));
    assign empty_s = (level_r == {LVL_W{1'b0}});
    assign push_s  = push & ~full_s;
    assign pop_s   = pop & ~empty_s;

    assign rd_data = mem_r[rd_ptr_r];
    assign full    = full_s;
    assign empty   = empty_s;
    assign level   = level_r;

    // Storage write; contents need no reset because the level gates reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and level bookkeeping; a push and pop together keep the level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/i2s_frame_feeder.sv
// Stereo sample buffer in front of the I2S DAC serializer. Frames from the
// DSP are queued; each falling edge of lrclk pops a frame and presents the
// left sample, each rising edge presents the right sample of that frame.
// An empty FIFO at a falling edge is an underrun: a sticky flag is set and a
// saturating counter advances.
//
// Build option I2S_UNDERRUN_HOLD_EN:
//   defined   - on underrun the last frame is replayed (hold registers kept)
//   undefined - on underrun the hold registers clear, so silence is output
module i2s_frame_feeder
    import i2s_pkg::*;
#(
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 8,
    parameter int UCNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    i2s_frame_feeder_if.slave             s_if,
    input  logic                          lrclk,
    output logic [I2S_WORD_W-1:0]         data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    input  logic                          underrun_clr,
    output logic [UCNT_W-1:0]             underrun_cnt
);

    localparam int FRAME_W = 2 * DATA_W;

    // lrclk synchronizer, previous value and registered edge strobes
    i2s_ch_e             sync1_r;
    i2s_ch_e             sync2_r;
    i2s_ch_e             prev_r;
    logic                fall_r;
    logic                rise_r;

    // control
    feeder_state_e       state_r;
    feeder_state_e       state_nxt_s;
    logic                run_r;
    logic                pop_s;
    logic                und_evt_s;
    logic                show_right_s;
    logic                push_s;

    // datapath
    logic [DATA_W-1:0]   hold_left_r;
    logic [DATA_W-1:0]   hold_right_r;
    logic [I2S_WORD_W-1:0] data_r;
    logic                underrun_r;
    logic [UCNT_W-1:0]   ucnt_r;

    // FIFO interface
    logic [FRAME_W-1:0]  fifo_rd_s;
    logic                full_s;
    logic                empty_s;
    logic [$clog2(FIFO_DEPTH):0] level_s;

    // Ready comes only from registers: out of reset and not full. A full
    // FIFO refuses a push even if a pop happens on the same edge.
    assign s_if.s_ready = run_r & ~full_s;
    assign push_s       = s_if.s_valid & s_if.s_ready;

    i2s_sample_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_s),
        .wr_data ({s_if.s_left, s_if.s_right}),
        .pop     (pop_s),
        .rd_data (fifo_rd_s),
        .full    (full_s),
        .empty   (empty_s),
        .level   (level_s)
    );

    // Synchronize lrclk and register fall/rise strobes (three edges of delay).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= CH_LEFT;
            sync2_r <= CH_LEFT;
            prev_r  <= CH_LEFT;
            fall_r  <= 1'b0;
            rise_r  <= 1'b0;
        end else begin
            sync1_r <= i2s_ch_e'(lrclk);
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            fall_r  <= (prev_r == CH_RIGHT) && (sync2_r == CH_LEFT);
            rise_r  <= (prev_r == CH_LEFT) && (sync2_r == CH_RIGHT);
        end
    end

    // Ready-enable flag that rises on the first clock after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and per-edge actions. The arming fall is handled like any
    // later fall (pop or underrun); rises only act once armed.
    always_comb begin
        state_nxt_s  = state_r;
        pop_s        = 1'b0;
        und_evt_s    = 1'b0;
        show_right_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fall_r) begin
                    state_nxt_s = ST_ARMED;
                    pop_s       = ~empty_s;
                    und_evt_s   = empty_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (fall_r) begin
                    state_nxt_s = ST_ARMED;
                    pop_s       = ~empty_s;
                    und_evt_s   = empty_s;
                end else if (rise_r) begin
                    state_nxt_s  = ST_ARMED;
                    show_right_s = 1'b1;
                end else begin
                    state_nxt_s = ST_ARMED;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Hold registers and the serializer word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_left_r  <= {DATA_W{1'b0}};
            hold_right_r <= {DATA_W{1'b0}};
            data_r       <= {I2S_WORD_W{1'b0}};
        end else if (pop_s) begin
            hold_left_r  <= fifo_rd_s[FRAME_W-1:DATA_W];
            hold_right_r <= fifo_rd_s[DATA_W-1:0];
            data_r       <= align_word(I2S_WORD_W'(fifo_rd_s[FRAME_W-1:DATA_W]), DATA_W);
        end else if (und_evt_s) begin
`ifdef I2S_UNDERRUN_HOLD_EN
            hold_left_r  <= hold_left_r;
            hold_right_r <= hold_right_r;
            data_r       <= align_word(I2S_WORD_W'(hold_left_r), DATA_W);
`else
            hold_left_r  <= {DATA_W{1'b0}};
            hold_right_r <= {DATA_W{1'b0}};
            data_r       <= {I2S_WORD_W{1'b0}};
`endif
        end else if (show_right_s) begin
            data_r <= align_word(I2S_WORD_W'(hold_right_r), DATA_W);
        end else begin
            data_r <= data_r;
        end
    end

    // Sticky underrun flag and saturating counter; a clear beats a new event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            underrun_r <= 1'b0;
            ucnt_r     <= {UCNT_W{1'b0}};
        end else if (underrun_clr) begin
            underrun_r <= 1'b0;
            ucnt_r     <= {UCNT_W{1'b0}};
        end else if (und_evt_s) begin
            underrun_r <= 1'b1;
            if (ucnt_r != {UCNT_W{1'b1}}) begin
                ucnt_r <= ucnt_r + UCNT_W'(1);
            end
        end
    end

    assign data         = data_r;
    assign fifo_level   = level_s;
    assign underrun     = underrun_r;
    assign underrun_cnt = ucnt_r;

endmodule
